// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if : decoded-instruction field bus into instr_encoder.
//
// Handshake: the master holds in_valid and all fields stable for as long as it
// wants the transfer. A transfer happens on every rising clock edge where
// in_valid and in_ready are both 1. in_ready never depends on in_valid. The
// master may drop in_valid at any time without a transfer having happened.
//
// Signals:
//   in_valid  master->slave  fields below are valid
//   in_ready  slave->master  encoder accepts fields this cycle
//   op_class  master->slave  0 R, 1 I-ALU, 2 JALR, 3 LW, 4 S, 5 B, 6 LUI, 7 JAL
//   alu_op    master->slave  ALU code (R/I) or branch funct3 (B)
//   rd/rs1/rs2 master->slave register indices
//   imm       master->slave  signed immediate (byte offset for B/JAL)
// ---------------------------------------------------------------------------
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op_class;
   logic [2:0]  alu_op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;

   modport master (output in_valid, op_class, alu_op, rd, rs1, rs2, imm,
                   input  in_ready);
   modport slave  (input  in_valid, op_class, alu_op, rd, rs1, rs2, imm,
                   output in_ready);
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder : packs decoded RV32I fields into machine words and writes
// them sequentially into instruction memory starting at base_addr.
//
// Optional feature macro: INSTR_ENC_PAD_EN -- when defined, finish from LOAD
// appends four addi x0,x0,0 words (PAD state) before returning to IDLE.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          pulse: load base_addr, clear counters/err, enter LOAD
//   base_addr      first word address written after start
//   finish         pulse: end of program
//   fld            field bus (slave side of instr_encoder_if)
//   imem_we        one-cycle write strobe per word
//   imem_addr      write address
//   imem_wdata     encoded word
//   busy           state != IDLE
//   full           state == FULL
//   err            sticky: an illegal field combination was rejected
//   words_written  words written since start, pad words included
//   state_dbg      current FSM state encoding
// ---------------------------------------------------------------------------
module instr_encoder #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              finish,
   instr_encoder_if.slave    fld,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              full,
   output logic              err,
   output logic [ADDR_W:0]   words_written,
   output logic [1:0]        state_dbg
);

`ifdef INSTR_ENC_PAD_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_PAD = 2'd2, S_FULL = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_FULL = 2'd3} state_t;
`endif

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   localparam logic [ADDR_W-1:0] PTR_MAX = '1;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE = 1;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [1:0]        pad_cnt;
   // finish arrived together with the word that filled memory: leave FULL
   // on the next cycle without waiting for another finish.
   logic              fin_pend;

   logic [31:0] word;
   logic        legal;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        fit12, fit13, fit21;
   logic        accept, last_legal;

   assign fld.in_ready = (state == S_LOAD);
   assign busy         = (state != S_IDLE);
   assign full         = (state == S_FULL);
   assign state_dbg    = state;

   assign accept     = fld.in_valid & fld.in_ready;
   assign last_legal = accept & legal & (ptr == PTR_MAX);

   // Signed-fit tests: every bit above the sign bit equals the sign bit.
   assign fit12 = (fld.imm[31:11] == {21{fld.imm[11]}});
   assign fit13 = (fld.imm[31:12] == {20{fld.imm[12]}});
   assign fit21 = (fld.imm[31:20] == {12{fld.imm[20]}});

   // Field packing; fields a format does not carry simply do not appear.
   always_comb begin
      word  = 32'h0;
      legal = 1'b0;
      f3    = 3'b000;
      f7    = 7'b0000000;
      case (fld.op_class)
         3'd0: begin
            legal = 1'b1;
            case (fld.alu_op)
               3'b000:  f3 = 3'b000;
               3'b001:  f7 = 7'b0100000;
               3'b010:  f3 = 3'b111;
               3'b011:  f3 = 3'b110;
               3'b100:  f3 = 3'b010;
               default: legal = 1'b0;
            endcase
            word = {f7, fld.rs2, fld.rs1, f3, fld.rd, OP_R};
         end
         3'd1: begin
            legal = fit12;
            case (fld.alu_op)
               3'b000:  f3 = 3'b000;
               3'b011:  f3 = 3'b110;
               3'b101:  f3 = 3'b100;
               3'b100:  f3 = 3'b010;
               default: legal = 1'b0;
            endcase
            word = {fld.imm[11:0], fld.rs1, f3, fld.rd, OP_I};
         end
         3'd2: begin
            legal = fit12;
            word  = {fld.imm[11:0], fld.rs1, 3'b000, fld.rd, OP_JALR};
         end
         3'd3: begin
            legal = fit12;
            word  = {fld.imm[11:0], fld.rs1, 3'b010, fld.rd, OP_LW};
         end
         3'd4: begin
            legal = fit12;
            word  = {fld.imm[11:5], fld.rs2, fld.rs1, 3'b010, fld.imm[4:0], OP_S};
         end
         3'd5: begin
            legal = fit13 & ~fld.imm[0] & ~fld.alu_op[1];
            word  = {fld.imm[12], fld.imm[10:5], fld.rs2, fld.rs1, fld.alu_op,
                     fld.imm[4:1], fld.imm[11], OP_B};
         end
         3'd6: begin
            legal = (fld.imm[11:0] == 12'h000);
            word  = {fld.imm[31:12], fld.rd, OP_LUI};
         end
         default: begin
            legal = fit21 & ~fld.imm[0];
            word  = {fld.imm[20], fld.imm[10:1], fld.imm[11], fld.imm[19:12], fld.rd, OP_JAL};
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         ptr           <= '0;
         pad_cnt       <= 2'd0;
         fin_pend      <= 1'b0;
         imem_we       <= 1'b0;
         imem_addr     <= '0;
         imem_wdata    <= 32'h0;
         err           <= 1'b0;
         words_written <= '0;
      end else begin
         imem_we <= 1'b0;
         if (start) begin
            // start wins over everything, including finish and a handshake.
            state         <= S_LOAD;
            ptr           <= base_addr;
            pad_cnt       <= 2'd0;
            fin_pend      <= 1'b0;
            err           <= 1'b0;
            words_written <= '0;
         end else begin
            case (state)
               S_LOAD: begin
                  if (accept) begin
                     if (legal) begin
                        imem_we       <= 1'b1;
                        imem_addr     <= ptr;
                        imem_wdata    <= word;
                        words_written <= words_written + CNT_ONE;
                        if (ptr == PTR_MAX) begin
                           state    <= S_FULL;
                           fin_pend <= finish;
                        end else begin
                           ptr <= ptr + PTR_ONE;
                        end
                     end else begin
                        err <= 1'b1;
                     end
                  end
                  if (finish && !last_legal) begin
`ifdef INSTR_ENC_PAD_EN
                     state   <= S_PAD;
                     pad_cnt <= 2'd0;
`else
                     state   <= S_IDLE;
`endif
                  end
               end
`ifdef INSTR_ENC_PAD_EN
               S_PAD: begin
                  imem_we       <= 1'b1;
                  imem_addr     <= ptr;
                  imem_wdata    <= 32'h0000_0013;
                  words_written <= words_written + CNT_ONE;
                  if (ptr == PTR_MAX) begin
                     state <= S_FULL;
                  end else begin
                     ptr     <= ptr + PTR_ONE;
                     pad_cnt <= pad_cnt + 2'd1;
                     if (pad_cnt == 2'd3) state <= S_IDLE;
                  end
               end
`endif
               S_FULL: begin
                  if (finish || fin_pend) begin
                     state    <= S_IDLE;
                     fin_pend <= 1'b0;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder : directed bench for instr_encoder (ADDR_W = 8).
// A bench-side model tracks mode/pointer/count/err and an expected write
// queue; a compare process checks the DUT against it every cycle.
// ---------------------------------------------------------------------------
module tb_instr_encoder;
   localparam int AW = 8;
   localparam int M_IDLE = 0, M_LOAD = 1, M_PAD = 2, M_FULL = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          start, finish;
   logic [AW-1:0] base_addr;
   logic          imem_we, busy, full, err;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic [AW:0]   words_written;
   logic [1:0]    state_dbg;

   instr_encoder_if bus ();

   instr_encoder #(.ADDR_W(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .finish        (finish),
      .fld           (bus),
      .imem_we       (imem_we),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .busy          (busy),
      .full          (full),
      .err           (err),
      .words_written (words_written),
      .state_dbg     (state_dbg)
   );

`ifdef INSTR_ENC_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [AW+31:0] exp_q[$];
   int m_mode = M_IDLE;
   int m_ptr = 0;
   int m_cnt = 0;
   bit m_err = 1'b0;
   bit m_pend = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Encoding straight from the RV32I format tables.
   function automatic logic [31:0] model_word(input int op, input int alu, input int rd,
                                              input int rs1, input int rs2, input int imm,
                                              output bit ok);
      logic [31:0] u, w;
      int f3, f7;
      u = imm; f3 = 0; f7 = 0; ok = 1'b1; w = 0;
      case (op)
         0: begin
            case (alu)
               0: f3 = 0; 1: f7 = 32; 2: f3 = 7; 3: f3 = 6; 4: f3 = 2;
               default: ok = 1'b0;
            endcase
            w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
         end
         1: begin
            case (alu)
               0: f3 = 0; 3: f3 = 6; 5: f3 = 4; 4: f3 = 2;
               default: ok = 1'b0;
            endcase
            if (imm < -2048 || imm > 2047) ok = 1'b0;
            w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
         end
         2, 3: begin
            if (imm < -2048 || imm > 2047) ok = 1'b0;
            f3 = (op == 3) ? 2 : 0;
            w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7)
                | ((op == 3) ? 32'h03 : 32'h67);
         end
         4: begin
            if (imm < -2048 || imm > 2047) ok = 1'b0;
            w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                | ((u & 32'h1F) << 7) | 32'h23;
         end
         5: begin
            if (imm < -4096 || imm > 4095 || (imm % 2) != 0) ok = 1'b0;
            if (!(alu == 0 || alu == 1 || alu == 4 || alu == 5)) ok = 1'b0;
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                | (rs1 << 15) | (alu << 12) | (((u >> 1) & 32'hF) << 8)
                | (((u >> 11) & 1) << 7) | 32'h63;
         end
         6: begin
            if ((u & 32'hFFF) != 0) ok = 1'b0;
            w = (u & 32'hFFFF_F000) | (rd << 7) | 32'h37;
         end
         default: begin
            if (imm < -1048576 || imm > 1048575 || (imm % 2) != 0) ok = 1'b0;
            w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12)
                | (rd << 7) | 32'h6F;
         end
      endcase
      return w;
   endfunction

   // Per-cycle compare against the model (outputs settled 1 time unit after edge).
   always @(posedge clk) begin
      logic [AW+31:0] e;
      #1;
      if (rst) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_we", imem_we, 1);
            chk("imem_addr", imem_addr, e[AW+31:32]);
            chk("imem_wdata", imem_wdata, e[31:0]);
         end else begin
            chk("imem_we_quiet", imem_we, 0);
         end
         chk("in_ready", bus.in_ready, m_mode == M_LOAD);
         chk("busy", busy, m_mode != M_IDLE);
         chk("full", full, m_mode == M_FULL);
         chk("err", err, m_err);
         chk("words_written", words_written, m_cnt);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_write(input logic [31:0] w);
      logic [AW-1:0] pa;
      pa = m_ptr[AW-1:0];
      exp_q.push_back({pa, w});
      m_cnt++;
   endtask

   task automatic do_pad();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0; finish = 1'b0; start = 1'b0;
         @(posedge clk);
         push_write(32'h0000_0013);
         if (m_ptr == (1 << AW) - 1) begin
            m_mode = M_FULL;
            break;
         end
         m_ptr++;
         if (i == 3) m_mode = M_IDLE;
      end
   endtask

   task automatic send(input int op, input int alu, input int rd, input int rs1,
                       input int rs2, input int imm, input bit fin);
      logic [31:0] w;
      bit ok;
      @(negedge clk);
      start = 1'b0; finish = fin;
      bus.in_valid = 1'b1;
      bus.op_class = op[2:0]; bus.alu_op = alu[2:0];
      bus.rd = rd[4:0]; bus.rs1 = rs1[4:0]; bus.rs2 = rs2[4:0];
      bus.imm = imm;
      @(posedge clk);
      if (m_mode == M_LOAD) begin
         w = model_word(op, alu, rd, rs1, rs2, imm, ok);
         if (ok) begin
            push_write(w);
            if (m_ptr == (1 << AW) - 1) begin
               m_mode = M_FULL;
               m_pend = fin;
            end else begin
               m_ptr++;
            end
         end else begin
            m_err = 1'b1;
         end
         if (fin && m_mode == M_LOAD) m_mode = PAD_EN ? M_PAD : M_IDLE;
      end
      if (m_mode == M_PAD) do_pad();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid = 1'b0; finish = 1'b0; start = 1'b0;
         @(posedge clk);
         if (m_mode == M_FULL && m_pend) begin
            m_mode = M_IDLE; m_pend = 1'b0;
         end
      end
   endtask

   task automatic do_start(input int base, input bit with_fin);
      @(negedge clk);
      bus.in_valid = 1'b0; start = 1'b1; finish = with_fin; base_addr = base[AW-1:0];
      @(posedge clk);
      m_mode = M_LOAD; m_ptr = base; m_cnt = 0; m_err = 1'b0; m_pend = 1'b0;
   endtask

   task automatic do_finish();
      @(negedge clk);
      bus.in_valid = 1'b0; start = 1'b0; finish = 1'b1;
      @(posedge clk);
      if (m_mode == M_LOAD) m_mode = PAD_EN ? M_PAD : M_IDLE;
      else if (m_mode == M_FULL) begin m_mode = M_IDLE; m_pend = 1'b0; end
      if (m_mode == M_PAD) do_pad();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      m_mode = M_IDLE; m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_pend = 1'b0;
      #1;
      chk("rst_imem_we", imem_we, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_imem_wdata", imem_wdata, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      chk("rst_err", err, 0);
      chk("rst_words", words_written, 0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Literal check of the write visible right after the accepting edge.
   task automatic lit_write(input string name, input int addr, input logic [31:0] data);
      #1;
      chk({name, "_we"}, imem_we, 1);
      chk({name, "_addr"}, imem_addr, addr);
      chk({name, "_data"}, imem_wdata, data);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit ok;
      rst = 1'b0; start = 1'b0; finish = 1'b0; base_addr = '0;
      bus.in_valid = 1'b0; bus.op_class = '0; bus.alu_op = '0;
      bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;

      // Model pins: hand-encoded words.
      chk("pin_add",  model_word(0, 0, 3, 1, 2, 0, ok), 32'h002081B3);
      chk("pin_sub",  model_word(0, 1, 5, 6, 7, 0, ok), 32'h407302B3);
      chk("pin_lw",   model_word(3, 0, 4, 1, 0, 8, ok), 32'h0080A203);
      chk("pin_beq",  model_word(5, 0, 0, 1, 2, -8, ok), 32'hFE208CE3);
      chk("pin_sw",   model_word(4, 0, 0, 1, 2, -4, ok), 32'hFE20AE23);
      chk("pin_lui",  model_word(6, 0, 5, 0, 0, 32'h12345000, ok), 32'h123452B7);
      chk("pin_jal",  model_word(7, 0, 1, 0, 0, 2048, ok), 32'h001000EF);
      chk("pin_jalr", model_word(2, 0, 1, 2, 0, 4, ok), 32'h004100E7);
      chk("pin_slti", model_word(1, 4, 3, 4, 0, -1, ok), 32'hFFF22193);
      chk("pin_or",   model_word(0, 3, 1, 2, 3, 0, ok), 32'h003160B3);

      do_reset();
      idle(2);

      // add x3,x1,x2 at base 0x10
      do_start(32'h10, 1'b0);
      send(0, 0, 3, 1, 2, 0, 1'b0);
      lit_write("add", 32'h10, 32'h002081B3);
      chk("add_words", words_written, 1);
      idle(1);

      // sub then lw back-to-back, then beq
      do_start(32'h10, 1'b0);
      send(0, 1, 5, 6, 7, 0, 1'b0);
      lit_write("sub", 32'h10, 32'h407302B3);
      send(3, 0, 4, 1, 0, 8, 1'b0);
      lit_write("lw", 32'h11, 32'h0080A203);
      send(5, 0, 0, 1, 2, -8, 1'b0);
      lit_write("beq", 32'h12, 32'hFE208CE3);

      // illegal addi imm 2048, then a legal word at the same address
      send(1, 0, 1, 0, 0, 2048, 1'b0);
      #1;
      chk("illegal_no_we", imem_we, 0);
      chk("illegal_err", err, 1);
      send(1, 0, 1, 0, 0, 5, 1'b0);
      lit_write("after_illegal", 32'h13, 32'h00500093);

      // more illegal combinations (err stays set, nothing written)
      send(0, 5, 1, 2, 3, 0, 1'b0);
      send(1, 1, 1, 2, 0, 4, 1'b0);
      send(5, 2, 0, 1, 2, 8, 1'b0);
      send(5, 0, 0, 1, 2, 3, 1'b0);
      send(5, 0, 0, 1, 2, 4096, 1'b0);
      send(6, 0, 5, 0, 0, 32'h12345001, 1'b0);
      send(7, 0, 1, 0, 0, 3, 1'b0);
      send(7, 0, 1, 0, 0, 1048576, 1'b0);
      send(4, 0, 0, 1, 2, -2049, 1'b0);
      send(2, 0, 1, 2, 0, 4096, 1'b0);

      // legal mix, last one carrying finish
      send(4, 0, 0, 1, 2, -4, 1'b0);
      send(6, 0, 5, 0, 0, 32'h12345000, 1'b0);
      send(7, 0, 1, 0, 0, 2048, 1'b0);
      send(7, 0, 1, 0, 0, -1048576, 1'b0);
      send(5, 5, 0, 3, 4, 4094, 1'b0);
      send(2, 0, 1, 2, 0, 4, 1'b0);
      send(1, 4, 3, 4, 0, -1, 1'b0);
      send(0, 3, 1, 2, 3, 0, 1'b1);
      idle(3);

      // start and finish together: start wins
      do_start(32'h30, 1'b1);
      idle(1);
      chk("start_wins_busy", busy, 1);
      do_finish();
      idle(2);

      // fill the top four addresses
      do_start(32'hFC, 1'b0);
      for (int i = 0; i < 4; i++) send(0, 2, i + 1, 2, 3, 0, 1'b0);
      #1;
      chk("full_flag", full, 1);
      chk("full_ready", bus.in_ready, 0);
      idle(2);
      do_finish();
      idle(1);
      chk("full_to_idle", busy, 0);

      // last-address word with finish in the same cycle
      do_start(32'hFF, 1'b0);
      send(1, 0, 2, 0, 0, 7, 1'b1);
      idle(3);

      // one word then finish (pad words follow when enabled)
      do_start(32'h20, 1'b0);
      send(0, 0, 3, 1, 2, 0, 1'b1);
      idle(2);
      chk("pad_words", words_written, PAD_EN ? 5 : 1);
      chk("pad_busy", busy, 0);

      // padding runs into the last address
      do_start(32'hFD, 1'b0);
      send(0, 0, 3, 1, 2, 0, 1'b1);
      idle(2);
      do_finish();
      idle(2);

      // reset while a write is visible
      do_start(32'h40, 1'b0);
      send(0, 0, 3, 1, 2, 0, 1'b0);
      do_reset();
      idle(3);

      chk("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V RV32I instruction encoder and instruction-memory loader: accepts decoded instruction fields (op class, ALU code, registers, immediate) over a valid/ready handshake, packs them into 32-bit machine words, and writes them sequentially into the core's instruction memory. It is the inverse of the decode stage's control unit. It uses the same op classes and ALU control codes, so test programs and self-modifying loads can be generated in-fabric and round-tripped through decode.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse: load base_addr, clear counters and err, enter LOAD
- base_addr  in  ADDR_W  first word address written after start
- finish  in  1  pulse: end of program; return to IDLE (via PAD if enabled)
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts fields this cycle
- op_class  in  3  0 R, 1 I-ALU, 2 JALR, 3 LW, 4 S, 5 B, 6 LUI, 7 JAL
- alu_op  in  3  ALU control code (R/I), branch funct3 (B); ignored otherwise
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  signed immediate (byte offset for B/JAL; upper value for LUI)
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- busy  out  1  state != IDLE
- full  out  1  state == FULL
- err  out  1  sticky: an illegal field combination was rejected
- words_written  out  ADDR_W+1  words written since start, pad words included

## Operation
- Opcodes: R 0110011, I 0010011, JALR 1100111, LW 0000011, S 0100011, B 1100011, LUI 0110111, JAL 1101111.
- R funct7/funct3 by alu_op: 000 add 0000000/000; 001 sub 0100000/000; 010 and /111; 011 or /110; 100 slt /010. Other codes are illegal.
- I funct3 by alu_op: 000 addi 000; 011 ori 110; 101 xori 100; 100 slti 010. Other codes are illegal.
- LW/S funct3 010. JALR funct3 000. B funct3 = alu_op, legal only for 000, 001, 100, 101.
- Immediate packing uses the standard RV32I I/S/B/U/J layouts.
- Range checks:
  - I/S/LW/JALR: imm must sign-fit 12 bits.
  - B: imm[0]=0 and imm must sign-fit 13 bits.
  - JAL: imm[0]=0 and imm must sign-fit 21 bits.
  - LUI: imm[11:0] must be 0.
- Unused fields (e.g. rs2 for I-type) are forced to 0 in the word.
- Illegal word: err set, no write, address and count unchanged, handshake still completes.
- FSM states: IDLE, LOAD, PAD (macro only), FULL.
  - IDLE→LOAD on start.
  - LOAD→FULL when a legal word is written at address 2^ADDR_W−1; the address does not wrap.
  - LOAD→IDLE (or PAD) on finish.
  - FULL→IDLE on finish.
  - start in any state restarts into LOAD.
- in_ready = 1 only in LOAD.

## Timing
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, full 0, err 0, words_written 0; state IDLE.
- Accept at edge N (in_valid & in_ready). At that same edge the registered outputs load: imem_we=1, imem_addr=ptr, imem_wdata=word; ptr and count increment.
- Write is visible during cycle N+1 and is sampled by memory at edge N+1. Latency is 1 cycle.
- Back-to-back writes at 1 word/cycle.
- imem_we is 0 in any cycle without a legal accept or pad word.
- Simultaneous events:
  - start and finish together: start wins.
  - finish with a handshake: the word is accepted and written, then the transition occurs.
  - A legal accept that fills the last address with finish in the same cycle: go to FULL→IDLE next.
- rst asserted mid-operation: all outputs return to reset values immediately; any in-flight write is dropped.

## Configuration
- INSTR_ENC_PAD_EN defined:
  - finish from LOAD enters PAD, which writes 0x00000013 (addi x0,x0,0) on 4 consecutive cycles to flush the 5-stage pipeline, then goes to IDLE.
  - Padding stops early and enters FULL if the last address is written.
  - in_ready is 0 in PAD.
- INSTR_ENC_PAD_EN undefined: no PAD state; finish goes directly to IDLE with no extra writes.

## Test plan
- start, base 0x10; add x3,x1,x2 (op 0, alu 000) → imem_we 1 cycle later, addr 0x10, data 0x002081B3; words_written 1.
- sub x5,x6,x7, then lw x4,8(x1) back-to-back → 0x407302B3 @0x10, 0x0080A203 @0x11 on consecutive cycles.
- beq x1,x2,imm −8 (op 5, alu 000) → 0xFE208CE3.
- addi with imm 2048 → err=1, no imem_we, address unchanged; the next legal word is written at the same address.
- ADDR_W=2, base 0, 4 legal words → full=1 and in_ready=0 after the 4th; finish → IDLE; rst mid-stream clears all outputs.
- With INSTR_ENC_PAD_EN: 1 word then finish → 4 writes of 0x00000013 at the following addresses, words_written 5, then busy=0.
